// File: rtl/traffic_phase_sequencer.sv
// Round-robin N-approach traffic-light sequencer with a phase timer, priority requests
// and a flashing-yellow maintenance mode. Every output is decoded from registers.
//   state   | meaning
//   ALLRED  | clearance, all approaches red; next owner chosen at phase end
//   GREEN   | active_dir green, others red
//   YELLOW  | active_dir yellow, others red
//   FLASH   | all approaches yellow/dark, alternating every YELLOW_CYC cycles
module traffic_phase_sequencer #(
  parameter int NUM_DIRS   = 4,
  parameter int DIR_W      = 2,
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIRS-1:0]   prio_req,
  input  logic                  flash_en,
  output logic [2*NUM_DIRS-1:0] light_state,
  output logic [DIR_W-1:0]      active_dir,
  output logic                  timing_done
);

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_FLASH  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIR_W-1:0]  dir_q, dir_d;
  logic              flash_q, flash_d;

  logic [CNT_W-1:0]  dur_m1;
  logic              phase_end;
  logic [DIR_W-1:0]  prio_pick;
  logic [DIR_W-1:0]  rr_next;

  always_comb begin
    dur_m1 = CNT_W'(ALLRED_CYC - 1);
    case (state_q)
      S_GREEN:  dur_m1 = CNT_W'(GREEN_CYC - 1);
      S_YELLOW: dur_m1 = CNT_W'(YELLOW_CYC - 1);
      S_FLASH:  dur_m1 = CNT_W'(YELLOW_CYC - 1);
      default:  dur_m1 = CNT_W'(ALLRED_CYC - 1);
    endcase
  end

  assign phase_end = (cnt_q == dur_m1);

  // Descending scan so the lowest set index wins.
  always_comb begin
    prio_pick = '0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (prio_req[i]) prio_pick = DIR_W'(i);
    end
  end

  assign rr_next = (dir_q == DIR_W'(NUM_DIRS - 1)) ? '0 : dir_q + DIR_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    dir_d   = dir_q;
    flash_d = flash_q;
    if (phase_end) begin
      cnt_d = '0;
      case (state_q)
        S_ALLRED: begin
          if (flash_en) begin
            state_d = S_FLASH;
            flash_d = 1'b1;
          end else begin
            state_d = S_GREEN;
            dir_d   = (prio_req != '0) ? prio_pick : rr_next;
          end
        end
        S_GREEN:  state_d = S_YELLOW;
        S_YELLOW: state_d = S_ALLRED;
        S_FLASH: begin
          if (!flash_en) state_d = S_ALLRED;
          else           flash_d = ~flash_q;
        end
        default:  state_d = S_ALLRED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ALLRED;
      cnt_q   <= '0;
      dir_q   <= DIR_W'(NUM_DIRS - 1);
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      flash_q <= flash_d;
    end
  end

  always_comb begin
    light_state = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      case (state_q)
        S_GREEN:  if (dir_q == DIR_W'(d)) light_state[2*d +: 2] = 2'b01;
        S_YELLOW: if (dir_q == DIR_W'(d)) light_state[2*d +: 2] = 2'b10;
        S_FLASH:  light_state[2*d +: 2] = flash_q ? 2'b10 : 2'b11;
        default:  light_state[2*d +: 2] = 2'b00;
      endcase
    end
  end

  assign active_dir  = dir_q;
  assign timing_done = phase_end;

endmodule
